// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared datapath widths, PC step and 2-bit predictor states.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    // Global 2-bit saturating predictor states; prediction is state[1]
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pred_state_t;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_2bit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_2bit
//  Description : Single global 2-bit saturating branch predictor FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor_2bit
    import cpu_pkg::*;
#(
    parameter logic [1:0] PRED_INIT = 2'b01
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic update_i,
    input  logic taken_i,
    output logic pred_o
);

    pred_state_t state;

    // Saturating up/down counter trained by every resolved branch
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= pred_state_t'(PRED_INIT);
        end else if (update_i) begin
            case (state)
                SNT:     state <= taken_i ? WNT : SNT;
                WNT:     state <= taken_i ? WT  : SNT;
                WT:      state <= taken_i ? ST  : WNT;
                default: state <= taken_i ? ST  : WT;
            endcase
        end
    end

    assign pred_o = state[1];

endmodule
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Program counter, next-PC selection, flush generation and
//                resolved/mispredicted branch counters for the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [1:0]  PRED_INIT = 2'b01
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            PC_stall_i,
    input  logic            ID_branch_i,
    input  logic [XLEN-1:0] ID_target_i,
    input  logic            EX_branch_i,
    input  logic            EX_taken_i,
    input  logic            EX_pred_taken_i,
    input  logic [XLEN-1:0] EX_target_i,
    input  logic [XLEN-1:0] EX_fallthrough_i,
    output logic [XLEN-1:0] PC_o,
    output logic            predict_taken_o,
    output logic            IFID_flush_o,
    output logic            IDEX_flush_o,
    output logic [XLEN-1:0] branch_cnt_o,
    output logic [XLEN-1:0] mispred_cnt_o
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] recover_pc;
    logic [XLEN-1:0] branch_cnt;
    logic [XLEN-1:0] mispred_cnt;
    logic            pred;
    logic            mispredict;
    logic            id_redirect;

    branch_predictor_2bit #(
        .PRED_INIT (PRED_INIT)
    ) u_pred (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .update_i (EX_branch_i),
        .taken_i  (EX_taken_i),
        .pred_o   (pred)
    );

    // Redirect causes; all qualified by reset so nothing leaks out during it
    assign mispredict      = rst_i & EX_branch_i & (EX_taken_i != EX_pred_taken_i);
    assign predict_taken_o = rst_i & ID_branch_i & pred;
    assign id_redirect     = predict_taken_o & ~PC_stall_i & ~mispredict;
    assign recover_pc      = EX_taken_i ? EX_target_i : EX_fallthrough_i;

    assign IFID_flush_o    = mispredict | id_redirect;
    assign IDEX_flush_o    = mispredict;

    // Next-PC mux: a mispredict wins over a stall since ID is on the wrong path
    always_comb begin
        next_pc = pc + PC_STEP;
        if (mispredict) begin
            next_pc = recover_pc;
        end else if (PC_stall_i) begin
            next_pc = pc;
        end else if (id_redirect) begin
            next_pc = ID_target_i;
        end
    end

    // Program counter register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Saturating branch statistics counters
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (EX_branch_i && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

    assign PC_o          = pc;
    assign branch_cnt_o  = branch_cnt;
    assign mispred_cnt_o = mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Directed self-checking bench for fetch_pc_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        PC_stall_i;
    logic        ID_branch_i;
    logic [31:0] ID_target_i;
    logic        EX_branch_i;
    logic        EX_taken_i;
    logic        EX_pred_taken_i;
    logic [31:0] EX_target_i;
    logic [31:0] EX_fallthrough_i;
    logic [31:0] PC_o;
    logic        predict_taken_o;
    logic        IFID_flush_o;
    logic        IDEX_flush_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0100),
        .PRED_INIT (2'b01)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .PC_stall_i       (PC_stall_i),
        .ID_branch_i      (ID_branch_i),
        .ID_target_i      (ID_target_i),
        .EX_branch_i      (EX_branch_i),
        .EX_taken_i       (EX_taken_i),
        .EX_pred_taken_i  (EX_pred_taken_i),
        .EX_target_i      (EX_target_i),
        .EX_fallthrough_i (EX_fallthrough_i),
        .PC_o             (PC_o),
        .predict_taken_o  (predict_taken_o),
        .IFID_flush_o     (IFID_flush_o),
        .IDEX_flush_o     (IDEX_flush_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        EX_branch_i      = 1'b0;
        EX_taken_i       = 1'b0;
        EX_pred_taken_i  = 1'b0;
        EX_target_i      = 32'h0;
        EX_fallthrough_i = 32'h0;
    endtask

    task automatic ex_drive(input logic taken, input logic pred_taken,
                            input logic [31:0] tgt, input logic [31:0] fall);
        EX_branch_i      = 1'b1;
        EX_taken_i       = taken;
        EX_pred_taken_i  = pred_taken;
        EX_target_i      = tgt;
        EX_fallthrough_i = fall;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [1:0]  exp_st [4];
        exp_st[0] = 2'b01; exp_st[1] = 2'b10; exp_st[2] = 2'b11; exp_st[3] = 2'b11;

        rst_i       = 1'b0;
        PC_stall_i  = 1'b0;
        ID_branch_i = 1'b0;
        ID_target_i = 32'h0;
        ex_clear();
        tick();
        tick();

        // Reset state
        check("reset_pc", PC_o, 32'h100);
        check("reset_state", {30'h0, dut.u_pred.state}, 32'h1);
        check("reset_bcnt", branch_cnt_o, 32'h0);
        check("reset_mcnt", mispred_cnt_o, 32'h0);
        check("reset_flush", {30'h0, IFID_flush_o, IDEX_flush_o}, 32'h0);

        // Sequential fetch
        rst_i = 1'b1;
        #1;
        check("seq_pc0", PC_o, 32'h100);
        tick(); check("seq_pc1", PC_o, 32'h104);
        tick(); check("seq_pc2", PC_o, 32'h108);

        // Stall holds PC for two cycles
        PC_stall_i = 1'b1;
        #1; check("stall_noflush", {31'h0, IFID_flush_o}, 32'h0);
        tick(); check("stall_pc0", PC_o, 32'h108);
        tick(); check("stall_pc1", PC_o, 32'h108);
        PC_stall_i = 1'b0;
        tick(); check("stall_release", PC_o, 32'h10C);

        // Mispredict from weak-NT: actually taken to 0x300
        ex_drive(1'b1, 1'b0, 32'h300, 32'h110);
        #1;
        check("mp1_ifid", {31'h0, IFID_flush_o}, 32'h1);
        check("mp1_idex", {31'h0, IDEX_flush_o}, 32'h1);
        tick();
        ex_clear();
        #1;
        check("mp1_pc", PC_o, 32'h300);
        check("mp1_state", {30'h0, dut.u_pred.state}, 32'h2);
        check("mp1_bcnt", branch_cnt_o, 32'h1);
        check("mp1_mcnt", mispred_cnt_o, 32'h1);

        // Predicted-taken branch in ID redirects to 0x200
        ID_branch_i = 1'b1;
        ID_target_i = 32'h200;
        #1;
        check("idr_pred", {31'h0, predict_taken_o}, 32'h1);
        check("idr_ifid", {31'h0, IFID_flush_o}, 32'h1);
        check("idr_idex", {31'h0, IDEX_flush_o}, 32'h0);
        tick();
        check("idr_pc", PC_o, 32'h200);

        // Stall suppresses the ID redirect
        PC_stall_i = 1'b1;
        #1;
        check("stid_pred", {31'h0, predict_taken_o}, 32'h1);
        check("stid_ifid", {31'h0, IFID_flush_o}, 32'h0);
        tick();
        check("stid_pc", PC_o, 32'h200);

        // Mispredict with stall and ID branch both high
        ex_drive(1'b0, 1'b1, 32'h500, 32'h124);
        #1;
        check("mp2_pred", {31'h0, predict_taken_o}, 32'h1);
        check("mp2_ifid", {31'h0, IFID_flush_o}, 32'h1);
        check("mp2_idex", {31'h0, IDEX_flush_o}, 32'h1);
        tick();
        ex_clear();
        PC_stall_i  = 1'b0;
        ID_branch_i = 1'b0;
        #1;
        check("mp2_pc", PC_o, 32'h124);
        check("mp2_mcnt", mispred_cnt_o, 32'h2);
        check("mp2_state", {30'h0, dut.u_pred.state}, 32'h1);

        // Correctly predicted not-taken: no redirect, state 01 -> 00
        ex_drive(1'b0, 1'b0, 32'h900, 32'h900);
        #1;
        check("nt_idex", {31'h0, IDEX_flush_o}, 32'h0);
        tick();
        ex_clear();
        check("nt_pc", PC_o, 32'h128);
        check("nt_state", {30'h0, dut.u_pred.state}, 32'h0);

        // Four correctly predicted taken resolutions from strong-NT
        exp_pc = 32'h128;
        for (int i = 0; i < 4; i++) begin
            ex_drive(1'b1, 1'b1, 32'hA00, 32'hA04);
            tick();
            exp_pc = exp_pc + 32'd4;
            check("tk_state", {30'h0, dut.u_pred.state}, {30'h0, exp_st[i]});
            check("tk_pc", PC_o, exp_pc);
        end
        ex_clear();
        check("tk_bcnt", branch_cnt_o, 32'h7);
        check("tk_mcnt", mispred_cnt_o, 32'h2);

        // PC wraps modulo 2^32
        ex_drive(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        tick();
        ex_clear();
        check("wrap_pc0", PC_o, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc1", PC_o, 32'h0);
        check("wrap_bcnt", branch_cnt_o, 32'h8);
        check("wrap_mcnt", mispred_cnt_o, 32'h3);

        // Counters saturate at all-ones
        force dut.branch_cnt  = 32'hFFFF_FFFF;
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        release dut.mispred_cnt;
        ex_drive(1'b0, 1'b1, 32'h0, 32'h40);
        tick();
        ex_clear();
        check("sat_bcnt", branch_cnt_o, 32'hFFFF_FFFF);
        check("sat_mcnt", mispred_cnt_o, 32'hFFFF_FFFF);
        check("sat_pc", PC_o, 32'h40);

        // Reset in the middle of a mispredict and a taken prediction
        ID_branch_i = 1'b1;
        ID_target_i = 32'h800;
        ex_drive(1'b1, 1'b0, 32'h700, 32'h44);
        rst_i = 1'b0;
        #1;
        check("rstm_pred", {31'h0, predict_taken_o}, 32'h0);
        check("rstm_flush", {30'h0, IFID_flush_o, IDEX_flush_o}, 32'h0);
        tick();
        check("rstm_pc", PC_o, 32'h100);
        check("rstm_state", {30'h0, dut.u_pred.state}, 32'h1);
        check("rstm_bcnt", branch_cnt_o, 32'h0);
        check("rstm_mcnt", mispred_cnt_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch control stage sitting directly upstream of the IF/ID pipeline register. Owns the program counter, a single global 2-bit saturating branch predictor, and redirect/flush generation for the 5-stage pipeline. Its PC drives instruction memory and the IF/ID PC input. Its flush outputs drive the IF/ID and ID/EX registers.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PRED_INIT, 2'b01, predictor state loaded on reset (weakly not-taken)

Ports:
- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- PC_stall_i  in  1  hold PC (load-use hazard from hazard unit)
- ID_branch_i  in  1  instruction in ID is a conditional branch
- ID_target_i  in  32  branch target computed in ID
- EX_branch_i  in  1  a branch resolves in EX this cycle
- EX_taken_i  in  1  actual outcome of the EX branch
- EX_pred_taken_i  in  1  prediction carried down the pipe with the EX branch
- EX_target_i  in  32  taken target of the EX branch
- EX_fallthrough_i  in  32  PC+4 of the EX branch
- PC_o  out  32  current fetch PC (registered)
- predict_taken_o  out  1  prediction for the branch in ID (combinational)
- IFID_flush_o  out  1  squash IF/ID contents at next edge
- IDEX_flush_o  out  1  squash ID/EX contents at next edge
- branch_cnt_o  out  32  resolved-branch count (registered)
- mispred_cnt_o  out  32  misprediction count (registered)

## Operation
- Predictor state encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is state[1].
- predict_taken_o = ID_branch_i & state[1].
- mispredict = EX_branch_i & (EX_taken_i != EX_pred_taken_i).
- recover_pc = EX_taken_i ? EX_target_i : EX_fallthrough_i.
- id_redirect = predict_taken_o & !PC_stall_i & !mispredict.
- Next-PC priority, highest first:
  - mispredict → recover_pc
  - PC_stall_i → hold PC
  - id_redirect → ID_target_i
  - otherwise → PC_o + 4
- A mispredict overrides a stall, because the stalled ID instruction is on the wrong path.
- IFID_flush_o = mispredict | id_redirect.
- IDEX_flush_o = mispredict.
- Predictor update on every EX_branch_i:
  - taken → increment, saturating at 11
  - not taken → decrement, saturating at 00
- A same-cycle ID prediction uses the pre-update state.
- Counters:
  - branch_cnt_o increments on EX_branch_i.
  - mispred_cnt_o increments on mispredict.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 → 32'h0000_0000. No alignment checks.

## Timing
- Reset (rst_i low at a rising edge):
  - PC_o ← RESET_PC
  - state ← PRED_INIT
  - both counters ← 0
- While rst_i is low, predict_taken_o, IFID_flush_o and IDEX_flush_o are forced 0.
- Reset mid-redirect discards the redirect.
- Redirect latency:
  - A cause in cycle N (mispredict or id_redirect) is visible on PC_o in cycle N+1.
  - The flush output is asserted in cycle N and consumed by the pipeline registers at the N→N+1 edge.
- Taken-prediction cost: 1 bubble. Mispredict cost: 2 bubbles.
- Stall holds PC_o for every stalled cycle; no internal stall counting.
- Simultaneous mispredict and ID branch: ID branch is on the wrong path. No id_redirect; IFID_flush_o still asserts because of mispredict.
- Counter and predictor updates become visible the cycle after the resolving EX cycle.

## Structure
- Shared package cpu_pkg holds:
  - XLEN = 32
  - PC_STEP = 4
  - the predictor state localparams (SNT, WNT, WT, ST)
- One sub-module, branch_predictor_2bit:
  - inputs: clk_i, rst_i, update_i, taken_i
  - output: pred_o
  - holds the saturating FSM
- fetch_pc_unit contains the PC register, next-PC mux, flush logic and counters.

## Test plan
- Reset with RESET_PC = 32'h100, no branches, 4 cycles → PC_o = 100, 104, 108, 10C; flushes 0; counts 0.
- PC_stall_i high for 2 cycles at PC 108 → PC_o holds 108 for 2 cycles, then 10C.
- Predictor in state 10, ID_branch_i = 1, ID_target_i = 200 → predict_taken_o = 1, IFID_flush_o = 1; next PC_o = 200.
- EX mispredict: EX_pred_taken_i = 1, EX_taken_i = 0, EX_fallthrough_i = 0x124, with PC_stall_i and ID_branch_i also high → both flushes 1; next PC_o = 124; mispred_cnt_o = 1 next cycle; state 10 → 01.
- Four consecutive taken resolutions from state 00 → states 01, 10, 11, 11 (saturates).
- Preload both counters to FFFF_FFFF via force, then resolve a mispredict → both remain FFFF_FFFF.
